// File: rtl/dispatch_pkg.sv
// Shared constants and types for the 1-to-4 stream dispatcher.
// Channel count, destination width and slot state encoding live here.
package dispatch_pkg;

    localparam int DISP_NCH    = 4;
    localparam int DISP_DEST_W = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Round-robin successor; the pointer width makes 3 -> 0 wrap for free.
    function automatic logic [DISP_DEST_W-1:0] next_ptr(input logic [DISP_DEST_W-1:0] ptr);
        return ptr + DISP_DEST_W'(1);
    endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One-entry holding slot for a single dispatcher channel.
// A load in the same cycle as a drain replaces the held beat without a bubble.
module dispatch_slot
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (!load && ready) state_d = SLOT_EMPTY;
        endcase
        // A stalled full slot never sees load because the top holds in_ready low.
        if (load) data_d = d;
    end

    always_comb begin
        valid = (state_q == SLOT_FULL);
        q     = data_q;
    end

endmodule

// File: rtl/dispatch_1to4.sv
// Registered valid/ready 1-to-4 dispatcher: one input stream routed to four
// one-entry channel slots, addressed by in_dest or by a round-robin pointer.
module dispatch_1to4
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit RR    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DISP_DEST_W-1:0]     in_dest,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DISP_NCH*WIDTH-1:0]  out_data,
    output logic [DISP_NCH-1:0]        out_valid,
    input  logic [DISP_NCH-1:0]        out_ready,
    output logic [DISP_DEST_W-1:0]     rr_ptr
);

    logic [DISP_DEST_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DISP_DEST_W-1:0] target;
    logic                   accept;
    logic [DISP_NCH-1:0]    load;

    // in_ready depends only on the target slot, never on in_valid.
    always_comb begin
        target   = RR ? rr_ptr_q : in_dest;
        in_ready = ~out_valid[target] | out_ready[target];
        accept   = in_valid & in_ready;
        load     = accept ? (DISP_NCH'(1) << target) : '0;
        rr_ptr_d = (RR && accept) ? next_ptr(rr_ptr_q) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

    for (genvar k = 0; k < DISP_NCH; k++) begin : g_slot
        dispatch_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .d     (in_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .q     (out_data[k*WIDTH +: WIDTH])
        );

        // A stalled channel must present the same beat on the next cycle.
        a_stall_hold: assert property (
            @(posedge clk) disable iff (!rst_n)
            (out_valid[k] && !out_ready[k]) |=>
                (out_valid[k] && $stable(out_data[k*WIDTH +: WIDTH]))
        );
    end

    a_ptr_fixed: assert property (
        @(posedge clk) disable iff (!rst_n) (!RR) |-> (rr_ptr_q == '0)
    );

endmodule

// File: tb/tb_dispatch_1to4.sv
// Scoreboard bench for dispatch_1to4: an addressed and a round-robin instance
// share stimulus; per-channel expected queues are filled on accept and drained by a monitor.
module tb_dispatch_1to4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic [1:0]     in_dest;
    logic           in_valid;
    logic [3:0]     out_ready;
    logic           in_ready_a, in_ready_r;
    logic [4*W-1:0] out_data_a, out_data_r;
    logic [3:0]     out_valid_a, out_valid_r;
    logic [1:0]     rr_ptr_a, rr_ptr_r;

    always #5 clk = ~clk;

    dispatch_1to4 #(.WIDTH(W), .RR(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .rr_ptr(rr_ptr_a)
    );

    dispatch_1to4 #(.WIDTH(W), .RR(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
        .in_valid(in_valid), .in_ready(in_ready_r), .out_data(out_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .rr_ptr(rr_ptr_r)
    );

    // Reference model: index 0 = addressed instance, 1 = round-robin instance.
    logic [W-1:0] exp_q [2][4][$];
    int mrr = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare every channel against the queue head and pop on drain.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    logic          ov;
                    logic [W-1:0]  od;
                    ov = (d == 0) ? out_valid_a[k] : out_valid_r[k];
                    od = (d == 0) ? out_data_a[k*W +: W] : out_data_r[k*W +: W];
                    check($sformatf("valid dut%0d ch%0d", d, k), 32'(ov),
                          32'(exp_q[d][k].size() != 0));
                    if (exp_q[d][k].size() != 0) begin
                        if (ov)
                            check($sformatf("data dut%0d ch%0d", d, k), 32'(od), 32'(exp_q[d][k][0]));
                        if (out_ready[k])
                            void'(exp_q[d][k].pop_front());
                    end
                end
            end
            check("rr_ptr addressed", 32'(rr_ptr_a), 32'd0);
            check("rr_ptr roundrobin", 32'(rr_ptr_r), 32'(mrr));
        end
    end

    // Drive one cycle; after the monitor has run, predict in_ready and record accepted beats.
    task automatic cycle(input logic v, input logic [1:0] dst, input logic [W-1:0] dat,
                         input logic [3:0] rdy, output logic acc_a, output logic acc_r);
        logic exp_rdy_a, exp_rdy_r;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_dest   = dst;
        in_data   = dat;
        out_ready = rdy;
        #6;
        exp_rdy_a = (exp_q[0][dst].size() == 0) || rdy[dst];
        exp_rdy_r = (exp_q[1][mrr].size() == 0) || rdy[mrr];
        check("in_ready addressed", 32'(in_ready_a), 32'(exp_rdy_a));
        check("in_ready roundrobin", 32'(in_ready_r), 32'(exp_rdy_r));
        acc_a = v && exp_rdy_a;
        acc_r = v && exp_rdy_r;
        if (acc_a) exp_q[0][dst].push_back(dat);
        if (acc_r) begin
            exp_q[1][mrr].push_back(dat);
            mrr = (mrr + 1) % 4;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset out_valid addressed", 32'(out_valid_a), 32'd0);
        check("reset out_valid roundrobin", 32'(out_valid_r), 32'd0);
        check("reset out_data addressed", out_data_a, 32'd0);
        check("reset rr_ptr roundrobin", 32'(rr_ptr_r), 32'd0);
        check("reset in_ready addressed", 32'(in_ready_a), 32'd1);
        check("reset in_ready roundrobin", 32'(in_ready_r), 32'd1);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                exp_q[d][k].delete();
        mrr = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic aa, ar;
        logic [3:0] rdy;
        int cnt, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
        do_reset();

        // Reset mid-stream with ch2 holding a stalled beat.
        cycle(1'b1, 2'd2, 8'h77, 4'b1011, aa, ar);
        cycle(1'b1, 2'd3, 8'h88, 4'b1011, aa, ar);
        check("ch2 full before reset", 32'(out_valid_a[2]), 32'd1);
        do_reset();

        // Addressed beat to ch3.
        cycle(1'b1, 2'd3, 8'hA1, 4'hF, aa, ar);
        cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);
        check("ch3 only valid", 32'(out_valid_a), 32'b1000);
        check("ch3 data", 32'(out_data_a[31:24]), 32'hA1);
        check("other channels data", 32'(out_data_a[23:0]), 32'd0);

        // Isolation: ch1 stalled, ch2 still reachable.
        cycle(1'b1, 2'd1, 8'h11, 4'b1101, aa, ar);
        cycle(1'b1, 2'd1, 8'h22, 4'b1101, aa, ar);
        check("ch1 stall in_ready", 32'(in_ready_a), 32'd0);
        cycle(1'b1, 2'd2, 8'h33, 4'b1101, aa, ar);
        check("ch2 in_ready while ch1 stalled", 32'(in_ready_a), 32'd1);
        cycle(1'b0, 2'd0, 8'h00, 4'b1101, aa, ar);
        check("ch2 data 33", 32'(out_data_a[23:16]), 32'h33);
        check("ch1 held valid", 32'(out_valid_a[1]), 32'd1);
        check("ch1 held data", 32'(out_data_a[15:8]), 32'h11);
        cycle(1'b1, 2'd1, 8'h22, 4'hF, aa, ar);
        repeat (2) cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);

        // Drain and load on ch0 in the same cycle.
        cycle(1'b1, 2'd0, 8'h55, 4'b1110, aa, ar);
        cycle(1'b1, 2'd0, 8'h66, 4'b1111, aa, ar);
        check("drain+load in_ready", 32'(in_ready_a), 32'd1);
        check("ch0 valid with 55", 32'(out_valid_a[0]), 32'd1);
        check("ch0 data 55", 32'(out_data_a[7:0]), 32'h55);
        cycle(1'b0, 2'd0, 8'h00, 4'b1110, aa, ar);
        check("ch0 valid kept", 32'(out_valid_a[0]), 32'd1);
        check("ch0 data 66", 32'(out_data_a[7:0]), 32'h66);
        repeat (2) cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);

        // Round-robin: six beats, all ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'd0, 8'(i), 4'hF, aa, ar);
            check("rr accept all ready", 32'(in_ready_r), 32'd1);
        end
        cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);
        check("rr_ptr after six", 32'(rr_ptr_r), 32'd2);

        // Round-robin with ch2 stalled: pointer parks on 2.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 2'd0, 8'(8'h10 + i), 4'b1011, aa, ar);
        for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 2'd0, 8'h14, 4'b1011, aa, ar);
            check("rr parked in_ready", 32'(in_ready_r), 32'd0);
            check("rr parked ptr", 32'(rr_ptr_r), 32'd2);
        end
        cycle(1'b1, 2'd0, 8'h14, 4'hF, aa, ar);
        check("rr released in_ready", 32'(in_ready_r), 32'd1);
        cycle(1'b1, 2'd0, 8'h15, 4'hF, aa, ar);
        repeat (2) cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);

        // Randomised traffic.
        cnt = 0;
        cyc = 0;
        while (cnt < 1000 && cyc < 20000) begin
            for (int k = 0; k < 4; k++) rdy[k] = ($urandom_range(0, 9) < 7);
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), rdy, aa, ar);
            if (aa) cnt++;
            cyc++;
        end
        if (cnt < 1000) check("random beat budget", 32'(cnt), 32'd1000);
        repeat (3) cycle(1'b0, 2'd0, 8'h00, 4'hF, aa, ar);
        check("drained addressed", 32'(out_valid_a), 32'd0);
        check("drained roundrobin", 32'(out_valid_r), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
